// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage MIPS core
//
// Purpose: detects load-use and branch-operand hazards, tracks the multi-cycle
// mult/div unit for HI/LO consumers, and sequences the IF/ID and ID/EX
// pipeline registers (stall, bubble, flush).
//
// Optional feature macro: HAZARD_PERF_EN (stall/flush performance counters).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ID_rs, ID_rt          source register fields of the instruction in ID
//   ID_UseRs, ID_UseRt    ID instruction actually reads rs / rt
//   ID_IsBranch           ID instruction compares registers in ID
//   Branch                branch/jump taken, resolved in ID
//   ID_MulDiv             ID instruction is mult/multu/div/divu
//   ID_ReadHiLo           ID instruction is mfhi/mflo
//   EX_WriteReg           destination register of the instruction in EX
//   EX_RegWrite           EX instruction writes a register
//   EX_MemRead            EX instruction is a load
//   PC_Write, IF_ID_Write front-end load enables
//   IF_Flush              zero the instruction entering IF/ID
//   ID_EX_Bubble          load a NOP into ID/EX
//   MD_Busy               mult/div unit occupied
//   Stall_Cnt, Flush_Cnt  performance counters (0 unless HAZARD_PERF_EN)

module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_IsBranch,
  input  logic        Branch,
  input  logic        ID_MulDiv,
  input  logic        ID_ReadHiLo,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_Flush,
  output logic        ID_EX_Bubble,
  output logic        MD_Busy,
  output logic [31:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_md_cnt;

  logic w_match;
  logic w_lu;
  logic w_brd;
  logic w_brl;
  logic w_mds;
  logic w_stall;
  logic w_flush;
  logic w_md_busy;

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  assign w_match = (EX_WriteReg != 5'd0) &&
                   ((ID_UseRs && (ID_rs == EX_WriteReg)) ||
                    (ID_UseRt && (ID_rt == EX_WriteReg)));

  assign w_lu      = EX_MemRead && w_match;
  assign w_brd     = ID_IsBranch && EX_RegWrite && !EX_MemRead && w_match;
  assign w_brl     = ID_IsBranch && EX_MemRead && w_match;
  assign w_md_busy = (r_md_cnt != 4'd0);
  assign w_mds     = (ID_MulDiv || ID_ReadHiLo) && w_md_busy;

  // A branch on a loaded value needs the load to reach MEM/WB before the ID
  // comparator sees it: one LU stall, then one extra BR_WAIT cycle.
  assign w_stall = w_lu || w_brd || (r_state == BR_WAIT) || w_mds;
  assign w_flush = Branch && !w_stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = RUN;
    case (r_state)
      RUN:     w_state_nxt = w_brl ? BR_WAIT : RUN;
      BR_WAIT: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Output logic; reset forces the front end frozen and ID/EX bubbled.
  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_Flush     = 1'b0;
    ID_EX_Bubble = 1'b1;
    MD_Busy      = 1'b0;
    if (rst_n) begin
      PC_Write     = !w_stall;
      IF_ID_Write  = !w_stall;
      IF_Flush     = w_flush;
      ID_EX_Bubble = w_stall;
      MD_Busy      = w_md_busy;
    end
  end

  // Mult/div occupancy. MDS stalls any issue attempt while busy, so a reload
  // can only happen once the counter has drained to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= 4'd0;
    end else if (ID_MulDiv && !w_stall) begin
      r_md_cnt <= 4'(MD_LAT);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`else
  assign Stall_Cnt = 32'd0;
  assign Flush_Cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UseRs;
  logic        ID_UseRt;
  logic        ID_IsBranch;
  logic        Branch;
  logic        ID_MulDiv;
  logic        ID_ReadHiLo;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite;
  logic        EX_MemRead;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_Flush;
  logic        ID_EX_Bubble;
  logic        MD_Busy;
  logic [31:0] Stall_Cnt;
  logic [15:0] Flush_Cnt;

  int n_checks;
  int n_pass;
  int exp_stall;
  int exp_flush;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_UseRs    (ID_UseRs),
    .ID_UseRt    (ID_UseRt),
    .ID_IsBranch (ID_IsBranch),
    .Branch      (Branch),
    .ID_MulDiv   (ID_MulDiv),
    .ID_ReadHiLo (ID_ReadHiLo),
    .EX_WriteReg (EX_WriteReg),
    .EX_RegWrite (EX_RegWrite),
    .EX_MemRead  (EX_MemRead),
    .PC_Write    (PC_Write),
    .IF_ID_Write (IF_ID_Write),
    .IF_Flush    (IF_Flush),
    .ID_EX_Bubble(ID_EX_Bubble),
    .MD_Busy     (MD_Busy),
    .Stall_Cnt   (Stall_Cnt),
    .Flush_Cnt   (Flush_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
    ID_IsBranch = 1'b0; Branch = 1'b0; ID_MulDiv = 1'b0; ID_ReadHiLo = 1'b0;
    EX_WriteReg = 5'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    Branch = 1'b1;
    tick();
    n_checks++;
    if ({PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, MD_Busy} !== 5'b00010)
      $display("FAIL reset_outputs: got %b expected 00010",
               {PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, MD_Busy});
    else n_pass++;
    n_checks++;
    if (Stall_Cnt !== 32'd0 || Flush_Cnt !== 16'd0)
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", Stall_Cnt, Flush_Cnt);
    else n_pass++;
    clear_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, ID_EX_Bubble, MD_Busy} !== 3'b100)
      $display("FAIL reset_release: got %b expected 100", {PC_Write, ID_EX_Bubble, MD_Busy});
    else n_pass++;
  endtask

  task automatic test_load_use();
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd8;
    ID_rs = 5'd8; ID_UseRs = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== 3'b001)
      $display("FAIL load_use_stall: got %b expected 001", {PC_Write, IF_ID_Write, ID_EX_Bubble});
    else n_pass++;
    exp_stall++;
    tick();
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
    #1;
    n_checks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== 3'b110)
      $display("FAIL load_use_release: got %b expected 110", {PC_Write, IF_ID_Write, ID_EX_Bubble});
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_load();
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd8;
    ID_rs = 5'd8; ID_UseRs = 1'b1; ID_IsBranch = 1'b1; Branch = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, IF_Flush, ID_EX_Bubble} !== 3'b001)
      $display("FAIL br_load_c0: got %b expected 001", {PC_Write, IF_Flush, ID_EX_Bubble});
    else n_pass++;
    exp_stall++;
    tick();
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
    #1;
    n_checks++;
    if ({PC_Write, IF_Flush, ID_EX_Bubble} !== 3'b001)
      $display("FAIL br_load_c1: got %b expected 001", {PC_Write, IF_Flush, ID_EX_Bubble});
    else n_pass++;
    exp_stall++;
    tick();
    n_checks++;
    if ({PC_Write, IF_Flush, ID_EX_Bubble} !== 3'b110)
      $display("FAIL br_load_c2: got %b expected 110", {PC_Write, IF_Flush, ID_EX_Bubble});
    else n_pass++;
    exp_flush++;
    tick();
    clear_inputs();
    #1;
  endtask

  task automatic test_branch_alu();
    EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
    ID_rt = 5'd9; ID_UseRt = 1'b1; ID_IsBranch = 1'b1; Branch = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, IF_Flush, ID_EX_Bubble} !== 3'b001)
      $display("FAIL br_alu_stall: got %b expected 001", {PC_Write, IF_Flush, ID_EX_Bubble});
    else n_pass++;
    exp_stall++;
    tick();
    EX_RegWrite = 1'b0;
    #1;
    n_checks++;
    if ({PC_Write, IF_Flush, ID_EX_Bubble} !== 3'b110)
      $display("FAIL br_alu_flush: got %b expected 110", {PC_Write, IF_Flush, ID_EX_Bubble});
    else n_pass++;
    exp_flush++;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (IF_Flush !== 1'b0)
      $display("FAIL br_alu_flush_once: got %b expected 0", IF_Flush);
    else n_pass++;
  endtask

  task automatic test_muldiv();
    ID_MulDiv = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, MD_Busy} !== 2'b10)
      $display("FAIL md_issue: got %b expected 10", {PC_Write, MD_Busy});
    else n_pass++;
    tick();
    ID_MulDiv = 1'b0; ID_ReadHiLo = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if ({PC_Write, ID_EX_Bubble, MD_Busy} !== 3'b011)
        $display("FAIL md_wait_c%0d: got %b expected 011", i, {PC_Write, ID_EX_Bubble, MD_Busy});
      else n_pass++;
      exp_stall++;
      tick();
    end
    #1;
    n_checks++;
    if ({PC_Write, ID_EX_Bubble, MD_Busy} !== 3'b100)
      $display("FAIL md_done_c5: got %b expected 100", {PC_Write, ID_EX_Bubble, MD_Busy});
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back_md();
    ID_MulDiv = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if ({PC_Write, MD_Busy} !== 2'b01)
        $display("FAIL md_b2b_hold_c%0d: got %b expected 01", i, {PC_Write, MD_Busy});
      else n_pass++;
      exp_stall++;
      tick();
    end
    #1;
    n_checks++;
    if ({PC_Write, MD_Busy} !== 2'b10)
      $display("FAIL md_b2b_issue: got %b expected 10", {PC_Write, MD_Busy});
    else n_pass++;
    tick();
    ID_MulDiv = 1'b0;
    #1;
    n_checks++;
    if (MD_Busy !== 1'b1)
      $display("FAIL md_b2b_reload: got %b expected 1", MD_Busy);
    else n_pass++;
    repeat (5) tick();
    clear_inputs();
  endtask

  task automatic test_reg_zero();
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd0;
    ID_rs = 5'd0; ID_UseRs = 1'b1; ID_IsBranch = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, ID_EX_Bubble} !== 2'b10)
      $display("FAIL reg0_no_stall: got %b expected 10", {PC_Write, ID_EX_Bubble});
    else n_pass++;
    clear_inputs();
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd12;
    ID_rt = 5'd12; ID_UseRt = 1'b0;
    #1;
    n_checks++;
    if ({PC_Write, ID_EX_Bubble} !== 2'b10)
      $display("FAIL unused_rt_no_stall: got %b expected 10", {PC_Write, ID_EX_Bubble});
    else n_pass++;
    ID_UseRt = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, ID_EX_Bubble} !== 2'b01)
      $display("FAIL rt_load_use: got %b expected 01", {PC_Write, ID_EX_Bubble});
    else n_pass++;
    exp_stall++;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (PC_Write !== 1'b1)
      $display("FAIL rt_load_use_release: got %b expected 1", PC_Write);
    else n_pass++;
  endtask

  task automatic test_perf();
    n_checks++;
`ifdef HAZARD_PERF_EN
    if (Stall_Cnt !== 32'(exp_stall) || Flush_Cnt !== 16'(exp_flush))
      $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d",
               Stall_Cnt, Flush_Cnt, exp_stall, exp_flush);
    else n_pass++;
`else
    if (Stall_Cnt !== 32'd0 || Flush_Cnt !== 16'd0)
      $display("FAIL perf_tied_zero: got %0d/%0d expected 0/0", Stall_Cnt, Flush_Cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_op();
    ID_MulDiv = 1'b1;
    tick();
    ID_MulDiv = 1'b0; ID_ReadHiLo = 1'b1;
    #1;
    n_checks++;
    if (MD_Busy !== 1'b1)
      $display("FAIL rst_mid_pre_busy: got %b expected 1", MD_Busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({MD_Busy, ID_EX_Bubble, PC_Write, IF_Flush} !== 4'b0100)
      $display("FAIL rst_mid_mult: got %b expected 0100",
               {MD_Busy, ID_EX_Bubble, PC_Write, IF_Flush});
    else n_pass++;
    n_checks++;
    if (Stall_Cnt !== 32'd0 || Flush_Cnt !== 16'd0)
      $display("FAIL rst_mid_counters: got %0d/%0d expected 0/0", Stall_Cnt, Flush_Cnt);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({MD_Busy, PC_Write} !== 2'b01)
      $display("FAIL rst_mid_release: got %b expected 01", {MD_Busy, PC_Write});
    else n_pass++;
    clear_inputs();
    // Abort a branch-after-load sequence while it sits in BR_WAIT.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_rs = 5'd8; ID_UseRs = 1'b1;
    ID_IsBranch = 1'b1;
    tick();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({PC_Write, ID_EX_Bubble} !== 2'b10)
      $display("FAIL rst_mid_brwait: got %b expected 10", {PC_Write, ID_EX_Bubble});
    else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    exp_stall = 0;
    exp_flush = 0;
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_muldiv();
    test_back_to_back_md();
    test_reg_zero();
    test_perf();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
